// File: rtl/svm_batch_sched_if.sv
// Word-read request port from the batch scheduler (master) to data memory (slave).
interface svm_batch_sched_if #(
  parameter int AW = 32
);
  logic          rd_vld;
  logic          rd_rdy;
  logic [AW-1:0] rd_addr;

  modport master (output rd_vld, output rd_addr, input rd_rdy);
  modport slave  (input rd_vld, input rd_addr, output rd_rdy);
endinterface

// File: rtl/svm_batch_sched.sv
// SVM batch scheduler: fetches num_dim words per point in batches, launches compute, waits done.
// start -> first read 2 cycles, last read -> batch_start 1 cycle; reads hold addr while rd_rdy=0.
module svm_batch_sched #(
  parameter int BATCH_PTS = 16,
  parameter int AW        = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_done_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [31:0]         num_dim_i,
  input  logic [31:0]         num_pts_i,
  input  logic [AW-1:0]       data_base_i,
  input  logic [AW-1:0]       res_base_i,
  input  logic [31:0]         res_blk_size_i,
  svm_batch_sched_if.master   rd,
  output logic                batch_start_o,
  output logic [31:0]         batch_pts_o,
  output logic [AW-1:0]       res_addr_o,
  input  logic                batch_comp_done_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_FETCH, S_LAUNCH, S_WAIT_COMP, S_DONE, S_ERR
  } state_e;

  localparam logic [31:0] BP = 32'(BATCH_PTS);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] res_addr_q, res_addr_d;
  logic [31:0]   pts_left_q, pts_left_d;
  logic [31:0]   batch_pts_q, batch_pts_d;
  logic [31:0]   dim_cnt_q, dim_cnt_d;
  logic [31:0]   pt_cnt_q, pt_cnt_d;
  logic [31:0]   num_dim_q, num_dim_d;
  logic [31:0]   res_blk_q, res_blk_d;

  function automatic logic [31:0] clip_batch(input logic [31:0] n);
    return (n > BP) ? BP : n;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      res_addr_q  <= '0;
      pts_left_q  <= '0;
      batch_pts_q <= '0;
      dim_cnt_q   <= '0;
      pt_cnt_q    <= '0;
      num_dim_q   <= '0;
      res_blk_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      res_addr_q  <= res_addr_d;
      pts_left_q  <= pts_left_d;
      batch_pts_q <= batch_pts_d;
      dim_cnt_q   <= dim_cnt_d;
      pt_cnt_q    <= pt_cnt_d;
      num_dim_q   <= num_dim_d;
      res_blk_q   <= res_blk_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    res_addr_d  = res_addr_q;
    pts_left_d  = pts_left_q;
    batch_pts_d = batch_pts_q;
    dim_cnt_d   = dim_cnt_q;
    pt_cnt_d    = pt_cnt_q;
    num_dim_d   = num_dim_q;
    res_blk_d   = res_blk_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i && cfg_done_i) begin
          state_d    = S_CHECK;
          ptr_d      = data_base_i;
          res_addr_d = res_base_i;
          pts_left_d = num_pts_i;
          num_dim_d  = num_dim_i;
          res_blk_d  = res_blk_size_i;
        end
      end
      S_CHECK: begin
        if (num_dim_q == 32'd0 || pts_left_q == 32'd0) begin
          state_d = S_ERR;
        end else begin
          state_d     = S_FETCH;
          batch_pts_d = clip_batch(pts_left_q);
          dim_cnt_d   = '0;
          pt_cnt_d    = '0;
        end
      end
      S_FETCH: begin
        if (rd.rd_rdy) begin
          ptr_d = ptr_q + AW'(4);
          if (dim_cnt_q == num_dim_q - 32'd1) begin
            dim_cnt_d = '0;
            pt_cnt_d  = pt_cnt_q + 32'd1;
            if (pt_cnt_q == batch_pts_q - 32'd1) state_d = S_LAUNCH;
          end else begin
            dim_cnt_d = dim_cnt_q + 32'd1;
          end
        end
      end
      S_LAUNCH: state_d = S_WAIT_COMP;
      S_WAIT_COMP: begin
        if (batch_comp_done_i) begin
          pts_left_d = pts_left_q - batch_pts_q;
          res_addr_d = res_addr_q + AW'({res_blk_q[29:0], 2'b00});
          if (pts_left_d == 32'd0) begin
            state_d = S_DONE;
          end else begin
            // Next batch skips CHECK: both counts are already known non-zero.
            state_d     = S_FETCH;
            batch_pts_d = clip_batch(pts_left_d);
            dim_cnt_d   = '0;
            pt_cnt_d    = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_i) state_d = S_IDLE;
  end

  assign rd.rd_vld     = (state_q == S_FETCH);
  assign rd.rd_addr    = ptr_q;
  assign batch_start_o = (state_q == S_LAUNCH);
  assign batch_pts_o   = batch_pts_q;
  assign res_addr_o    = res_addr_q;
  assign busy_o        = (state_q == S_FETCH) || (state_q == S_LAUNCH) || (state_q == S_WAIT_COMP);
  assign done_o        = (state_q == S_DONE);
  assign err_o         = (state_q == S_ERR);

endmodule

// File: tb/tb_svm_batch_sched.sv
// Directed + randomized bench for svm_batch_sched against an arithmetic address/batch model.
module tb_svm_batch_sched;
  logic        clk = 1'b0;
  logic        rst_n, cfg_done, start, abort, comp_done;
  logic [31:0] num_dim, num_pts, data_base, res_base, res_blk;
  logic        batch_start, busy, done, err;
  logic [31:0] batch_pts, res_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  svm_batch_sched_if #(.AW(32)) rd_if ();

  svm_batch_sched #(.BATCH_PTS(16), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_done_i(cfg_done), .start_i(start), .abort_i(abort),
    .num_dim_i(num_dim), .num_pts_i(num_pts), .data_base_i(data_base), .res_base_i(res_base),
    .res_blk_size_i(res_blk), .rd(rd_if.master), .batch_start_o(batch_start),
    .batch_pts_o(batch_pts), .res_addr_o(res_addr), .batch_comp_done_i(comp_done),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 rdy always high, 1 rdy toggles 1-0-1, 2 random rdy.
  // kind: 0 abort, 1 synchronous reset, used when abort_after > 0.
  task automatic run_job(input string tag, input int nd, input int np,
                         input logic [31:0] db, input logic [31:0] rb, input logic [31:0] blk,
                         input int mode, input int abort_after, input int kind, input bit spurious);
    logic [31:0] got[$];
    int          bsz[$];
    logic [31:0] bres[$];
    int          first_vld, err_cyc, last_hs, bs_bad, hold_bad, bad, comp_wait, budget, nb, lim, cyc;
    bit          prev_stall, saw_vld, abort_pend, finished;
    logic [31:0] prev_addr, e;

    first_vld = -1; err_cyc = -1; last_hs = -100; bs_bad = 0; hold_bad = 0; bad = 0;
    comp_wait = 0; prev_stall = 0; saw_vld = 0; abort_pend = 0; finished = 0;
    prev_addr = '0;
    budget = nd * np * 4 + 12 * (np / 16 + 1) + 40;

    tick();
    num_dim = nd; num_pts = np; data_base = db; res_base = rb; res_blk = blk;
    cfg_done = 1'b1; start = 1'b1; comp_done = 1'b0; rd_if.rd_rdy = 1'b0;
    @(negedge clk);

    for (cyc = 1; cyc <= budget; cyc++) begin
      tick();
      start = 1'b0;
      // Captured config must not follow later input changes.
      num_dim = $urandom; num_pts = $urandom; data_base = $urandom; res_blk = $urandom;
      case (mode)
        0:       rd_if.rd_rdy = 1'b1;
        1:       rd_if.rd_rdy = (cyc % 2 == 1);
        default: rd_if.rd_rdy = ($urandom_range(0, 1) == 1);
      endcase
      comp_done = 1'b0;
      if (comp_wait > 0) begin
        comp_wait--;
        if (comp_wait == 0) comp_done = 1'b1;
      end else if (spurious && saw_vld && $urandom_range(0, 3) == 0) begin
        comp_done = 1'b1;
      end
      if (abort_pend) begin
        if (kind == 0) abort = 1'b1;
        else rst_n = 1'b0;
      end

      @(negedge clk);
      if (prev_stall && (!rd_if.rd_vld || rd_if.rd_addr !== prev_addr)) hold_bad++;
      if (rd_if.rd_vld && first_vld < 0) first_vld = cyc;
      if (rd_if.rd_vld && rd_if.rd_rdy) begin
        got.push_back(rd_if.rd_addr);
        last_hs = cyc;
      end
      prev_stall = rd_if.rd_vld && !rd_if.rd_rdy;
      prev_addr  = rd_if.rd_addr;
      saw_vld    = rd_if.rd_vld;
      if (batch_start) begin
        bsz.push_back(batch_pts);
        bres.push_back(res_addr);
        if (cyc != last_hs + 1) bs_bad++;
        comp_wait = $urandom_range(1, 4);
      end
      if (err && err_cyc < 0) err_cyc = cyc;
      if (abort_pend) begin
        tick();
        abort = 1'b0; rst_n = 1'b1; rd_if.rd_rdy = 1'b0; comp_done = 1'b0;
        @(negedge clk);
        chk({tag, " abort rd_vld"}, rd_if.rd_vld, 1'b0);
        chk({tag, " abort busy"}, busy, 1'b0);
        chk({tag, " abort done/err"}, {done, err}, 2'b00);
        if (kind == 1) begin
          chk({tag, " rst outputs"}, {batch_start, batch_pts, res_addr, rd_if.rd_addr},
              {1'b0, 32'd0, 32'd0, 32'd0});
        end
        for (int i = 0; i < got.size(); i++) if (got[i] !== db + 32'(i * 4)) bad++;
        chk({tag, " abort prefix bad"}, bad, 0);
        chk({tag, " abort reached"}, (got.size() >= abort_after), 1'b1);
        return;
      end
      if (abort_after > 0 && got.size() == abort_after) abort_pend = 1'b1;
      if (done || err) begin
        finished = 1'b1;
        break;
      end
    end
    comp_done = 1'b0;
    rd_if.rd_rdy = 1'b0;

    chk({tag, " finished in budget"}, finished, 1'b1);
    if (nd == 0 || np == 0) begin
      chk({tag, " err flags"}, {err, done, busy}, 3'b100);
      chk({tag, " err latency"}, err_cyc, 2);
      chk({tag, " err no reads"}, {got.size(), first_vld}, {32'd0, -32'sd1});
      return;
    end

    chk({tag, " done flags"}, {done, err, busy}, 3'b100);
    chk({tag, " first rd latency"}, first_vld, 2);
    chk({tag, " read count"}, got.size(), nd * np);
    for (int i = 0; i < got.size(); i++) begin
      e = db + 32'(i * 4);
      if (got[i] !== e) bad++;
    end
    chk({tag, " addr seq bad"}, bad, 0);
    chk({tag, " batch_start latency bad"}, bs_bad, 0);
    chk({tag, " hold while stalled bad"}, hold_bad, 0);
    nb = (np + 15) / 16;
    chk({tag, " batch count"}, bsz.size(), nb);
    lim = (bsz.size() < nb) ? bsz.size() : nb;
    for (int k = 0; k < lim; k++) begin
      chk({tag, " batch_pts"}, bsz[k], ((np - 16 * k) > 16) ? 16 : (np - 16 * k));
      chk({tag, " res_addr"}, bres[k], rb + 32'(k) * blk * 32'd4);
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_done = 1'b0; start = 1'b0; abort = 1'b0; comp_done = 1'b0;
    num_dim = '0; num_pts = '0; data_base = '0; res_base = '0; res_blk = '0;
    rd_if.rd_rdy = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset outputs", {rd_if.rd_vld, rd_if.rd_addr, batch_start, batch_pts, res_addr, busy, done, err},
        {1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0});
    tick();
    rst_n = 1'b1;

    run_job("t1", 2, 4, 32'h0, 32'h0, 32'd1, 0, 0, 0, 1'b0);
    run_job("t2", 3, 40, 32'h1000, 32'h200, 32'd1, 0, 0, 0, 1'b0);
    run_job("t3", 3, 10, 32'h40, 32'h80, 32'd2, 1, 0, 0, 1'b0);
    run_job("t4a", 0, 5, 32'h100, 32'h0, 32'd1, 0, 0, 0, 1'b0);
    run_job("t4b", 4, 0, 32'h100, 32'h0, 32'd1, 0, 0, 0, 1'b0);
    run_job("t4c", 2, 3, 32'h500, 32'h900, 32'd3, 2, 0, 0, 1'b0);

    // start with cfg_done low is ignored: DONE persists, nothing is read.
    tick();
    cfg_done = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("t5 ignored start", {done, busy, rd_if.rd_vld}, 3'b100);

    run_job("t5 spurious comp", 2, 20, 32'h2000, 32'h40, 32'd4, 2, 0, 0, 1'b1);
    run_job("t6 abort", 2, 40, 32'h3000, 32'h0, 32'd1, 2, 40, 0, 1'b0);
    run_job("t6 after abort", 2, 5, 32'h3000, 32'h10, 32'd1, 0, 0, 0, 1'b0);
    run_job("t6 reset", 2, 40, 32'h4000, 32'h0, 32'd1, 2, 45, 1, 1'b0);
    run_job("t6 after reset", 3, 17, 32'h4000, 32'h20, 32'd2, 2, 0, 0, 1'b0);
    run_job("wrap", 2, 20, 32'hFFFF_FFC0, 32'hFFFF_FFF0, 32'd2, 2, 0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      run_job("rand", $urandom_range(1, 5), $urandom_range(1, 40), $urandom & 32'hFFFF_FFFC,
              $urandom & 32'hFFFF_FFFC, $urandom_range(0, 7), 2, 0, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
